// File: rtl/pwm_multichannel.sv
// Multi-channel PWM with a shared period counter, edge/center alignment and
// double-buffered configuration that only commits on period boundaries.
module pwm_multichannel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int AW       = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    logic [WIDTH-1:0] duty_sh      [CHANNELS];
    logic [WIDTH-1:0] duty_act     [CHANNELS];
    logic [WIDTH-1:0] duty_sh_nxt  [CHANNELS];
    logic [WIDTH-1:0] max_sh, max_act, max_sh_nxt;
    logic             mode_sh, mode_act, mode_sh_nxt;
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             boundary;
    logic             commit;
    logic [CHANNELS-1:0] cmp;

    // Shadow values after this cycle's write; a commit loads these so a write
    // landing on the boundary cycle goes straight through to the active set.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        duty_sh_nxt = duty_sh;
        max_sh_nxt  = max_sh;
        mode_sh_nxt = mode_sh;
        if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == AW'(i)) duty_sh_nxt[i] = wr_data;
            end
            if (wr_addr == AW'(CHANNELS))     max_sh_nxt  = wr_data;
            if (wr_addr == AW'(CHANNELS + 1)) mode_sh_nxt = wr_data[0];
        end
    end

    // In center mode with max_act==1 the peak and the final down-count cycle
    // coincide, so cnt==1 ends the period regardless of direction.
    always_comb begin
        if (mode_act) begin
            boundary = (max_act == '0) ||
                       ((cnt == WIDTH'(1)) && (dir || (max_act == WIDTH'(1))));
        end else begin
            boundary = (cnt == max_act);
        end
        commit = !en || boundary;
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp[i] = (cnt < duty_act[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
            max_sh   <= '1;
            max_act  <= '1;
            mode_sh  <= 1'b0;
            mode_act <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            duty_sh <= duty_sh_nxt;
            max_sh  <= max_sh_nxt;
            mode_sh <= mode_sh_nxt;
            if (commit) begin
                duty_act <= duty_sh_nxt;
                max_act  <= max_sh_nxt;
                mode_act <= mode_sh_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dir <= 1'b0;
        end else if (commit) begin
            cnt <= '0;
            dir <= 1'b0;
        end else if (!mode_act) begin
            cnt <= cnt + WIDTH'(1);
        end else if (!dir && (cnt == max_act)) begin
            dir <= 1'b1;
            cnt <= cnt - WIDTH'(1);
        end else if (dir) begin
            cnt <= cnt - WIDTH'(1);
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= en ? cmp : '0;
            period_start <= en && (cnt == '0);
        end
    end

endmodule
